// File: rtl/hist_stream_logger.sv
// hist_stream_logger
//   Histogram logger for a sampled state vector. After a start pulse, every valid
//   sample bumps each bin whose tag equals the sample, or the miss counter when no
//   tag matches. Once the sample budget is used up, the bins and then the miss count
//   are streamed out over a valid/ready port. The results stay held until the next
//   start.
// Ports
//   i_clk, i_reset           clock; synchronous active-high reset
//   i_sample, i_sample_valid state vector and its qualifier
//   i_start, i_num_samples   acquisition start pulse and sample budget
//   i_cfg_we/addr/tag        tag table write port (IDLE/DONE only)
//   o_rd_valid, i_rd_ready   readout handshake
//   o_rd_idx/data/last       word index, count, final-word flag
//   o_busy, o_done           ACQUIRE|READOUT flag, DONE flag
module hist_stream_logger #(
  parameter int OUT_W    = 8,
  parameter int NUM_BINS = 90,
  parameter int CNT_W    = 32,
  localparam int BIN_AW  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1,
  localparam int RD_AW   = $clog2(NUM_BINS + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [OUT_W-1:0]  i_sample,
  input  logic              i_sample_valid,
  input  logic              i_start,
  input  logic [31:0]       i_num_samples,
  input  logic              i_cfg_we,
  input  logic [BIN_AW-1:0] i_cfg_addr,
  input  logic [OUT_W-1:0]  i_cfg_tag,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [RD_AW-1:0]  o_rd_idx,
  output logic [CNT_W-1:0]  o_rd_data,
  output logic              o_rd_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_READOUT, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_bin [NUM_BINS];
  logic [OUT_W-1:0]   r_tag [NUM_BINS];
  logic [CNT_W-1:0]   r_miss;
  logic [31:0]        r_smp_cnt;
  logic [31:0]        r_budget;
  logic [RD_AW-1:0]   r_rd_idx;

  logic [NUM_BINS-1:0] w_hit;
  logic               w_idle_like, w_start, w_cfg, w_count, w_rd_xfer, w_rd_end;
  logic [CNT_W-1:0]   w_word;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start     = i_start && w_idle_like;
  assign w_cfg       = i_cfg_we && w_idle_like && (int'(i_cfg_addr) < NUM_BINS);
  // The cycle on which the counter equals the budget only moves to READOUT;
  // that also makes a zero budget a one-cycle, count-nothing ACQUIRE.
  assign w_count     = (r_state == S_ACQUIRE) && i_sample_valid && (r_smp_cnt != r_budget);
  assign w_rd_xfer   = (r_state == S_READOUT) && i_rd_ready;
  assign w_rd_end    = (r_rd_idx == RD_AW'(NUM_BINS));

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_BINS; i++) w_hit[i] = (r_tag[i] == i_sample);
  end

  // Readout word mux; index NUM_BINS selects the miss counter.
  always_comb begin
    w_word = r_miss;
    for (int i = 0; i < NUM_BINS; i++)
      if (r_rd_idx == RD_AW'(i)) w_word = r_bin[i];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_start) w_next = S_ACQUIRE;
      S_ACQUIRE:      if (r_smp_cnt == r_budget) w_next = S_READOUT;
      S_READOUT:      if (w_rd_xfer && w_rd_end) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_miss    <= '0;
      r_smp_cnt <= '0;
      r_budget  <= '0;
      r_rd_idx  <= '0;
      for (int i = 0; i < NUM_BINS; i++) begin
        r_bin[i] <= '0;
        r_tag[i] <= OUT_W'(i);
      end
    end else begin
      r_state <= w_next;
      for (int i = 0; i < NUM_BINS; i++) begin
        if (w_cfg && (i_cfg_addr == BIN_AW'(i))) r_tag[i] <= i_cfg_tag;
        if (w_start)
          r_bin[i] <= '0;
        else if (w_count && w_hit[i] && (r_bin[i] != '1))
          r_bin[i] <= r_bin[i] + 1'b1;
      end
      if (w_start) begin
        r_miss    <= '0;
        r_smp_cnt <= '0;
        r_budget  <= i_num_samples;
        r_rd_idx  <= '0;
      end else begin
        if (w_count) r_smp_cnt <= r_smp_cnt + 1'b1;
        if (w_count && (w_hit == '0) && (r_miss != '1)) r_miss <= r_miss + 1'b1;
        if (w_rd_xfer) r_rd_idx <= w_rd_end ? '0 : r_rd_idx + 1'b1;
      end
    end
  end

  assign o_rd_valid = (r_state == S_READOUT);
  assign o_rd_idx   = r_rd_idx;
  assign o_rd_data  = o_rd_valid ? w_word : '0;
  assign o_rd_last  = o_rd_valid && w_rd_end;
  assign o_busy     = (r_state == S_ACQUIRE) || (r_state == S_READOUT);
  assign o_done     = (r_state == S_DONE);

endmodule

// File: tb/tb_hist_stream_logger.sv
// Directed bench for hist_stream_logger. Two instances share all inputs: the
// default one (CNT_W=32) and a CNT_W=4 one used for the saturation case.
module tb_hist_stream_logger;
  localparam int NB = 90;

  logic        clk = 0;
  logic        reset, sample_valid, start, cfg_we, rd_ready;
  logic [7:0]  sample, cfg_tag;
  logic [31:0] num_samples;
  logic [6:0]  cfg_addr;
  logic        rd_valid, rd_last, busy, done;
  logic [6:0]  rd_idx;
  logic [31:0] rd_data;
  logic        rd_valid4, rd_last4, busy4, done4;
  logic [6:0]  rd_idx4;
  logic [3:0]  rd_data4;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] got  [0:NB];
  logic [3:0]  got4 [0:NB];
  logic [31:0] held, sum;

  always #5 clk = ~clk;

  hist_stream_logger dut (
    .i_clk(clk), .i_reset(reset), .i_sample(sample), .i_sample_valid(sample_valid),
    .i_start(start), .i_num_samples(num_samples), .i_cfg_we(cfg_we),
    .i_cfg_addr(cfg_addr), .i_cfg_tag(cfg_tag), .o_rd_valid(rd_valid),
    .i_rd_ready(rd_ready), .o_rd_idx(rd_idx), .o_rd_data(rd_data),
    .o_rd_last(rd_last), .o_busy(busy), .o_done(done));

  hist_stream_logger #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_reset(reset), .i_sample(sample), .i_sample_valid(sample_valid),
    .i_start(start), .i_num_samples(num_samples), .i_cfg_we(cfg_we),
    .i_cfg_addr(cfg_addr), .i_cfg_tag(cfg_tag), .o_rd_valid(rd_valid4),
    .i_rd_ready(rd_ready), .o_rd_idx(rd_idx4), .o_rd_data(rd_data4),
    .o_rd_last(rd_last4), .o_busy(busy4), .o_done(done4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drain the stream from word 'from' with rd_ready held high.
  task automatic readout(input int from);
    for (int i = from; i <= NB; i++) begin
      rd_ready = 1;
      chk("rd_word", {rd_valid, rd_idx, rd_last}, {1'b1, 7'(i), (i == NB)});
      got[i]  = rd_data;
      got4[i] = rd_data4;
      tick();
    end
    rd_ready = 0;
  endtask

  task automatic push(input logic [7:0] s);
    sample_valid = 1;
    sample       = s;
    tick();
  endtask

  initial begin
    reset = 1; sample = 0; sample_valid = 0; start = 0; num_samples = 0;
    cfg_we = 0; cfg_addr = 0; cfg_tag = 0; rd_ready = 0;
    tick(); tick();
    reset = 0;
    chk("rst_outs", {rd_valid, rd_idx, rd_data, rd_last, busy, done}, 0);

    // Default tags: 3,3,7 hit, 17 hits bin17 (tag 17), 200 misses.
    start = 1; num_samples = 5; sample_valid = 1; sample = 3; tick();
    start = 0;
    chk("acq_busy", {busy, done, rd_valid}, 3'b100);
    push(3); push(3); push(7); push(200); push(17);
    sample_valid = 0;
    chk("acq_wait", {busy, rd_valid}, 2'b10);
    tick();
    chk("ro_enter", {busy, rd_valid}, 2'b11);
    readout(0);
    chk("t1_bin3", got[3], 2);
    chk("t1_bin7", got[7], 1);
    chk("t1_bin17", got[17], 1);
    chk("t1_bin0", got[0], 0);
    chk("t1_miss", got[NB], 1);
    chk("t1_done", {busy, done, rd_valid, rd_data}, {3'b010, 32'd0});

    // Duplicate tags, second tag write shares the cycle with start.
    cfg_we = 1; cfg_addr = 0; cfg_tag = 8'h55; tick();
    cfg_addr = 1; start = 1; num_samples = 2; tick();
    cfg_we = 0; start = 0;
    push(8'h55); push(8'h55);
    sample_valid = 0; tick();
    readout(0);
    chk("t2_bin0", got[0], 2);
    chk("t2_bin1", got[1], 2);
    chk("t2_bin85", got[85], 2);
    chk("t2_miss", got[NB], 0);

    // cfg_we during ACQUIRE ignored; rd_ready 1,0,0,1 with start during stall.
    start = 1; num_samples = 3; tick();
    start = 0;
    cfg_we = 1; cfg_addr = 2; cfg_tag = 8'h55; push(2);
    cfg_we = 0; push(2); push(8'h55);
    sample_valid = 0; tick();
    rd_ready = 1;
    chk("st_w0", {rd_valid, rd_idx, rd_last, rd_data}, {1'b1, 7'd0, 1'b0, 32'd1});
    got[0] = rd_data;
    tick();
    rd_ready = 0;
    chk("st_w1", {rd_valid, rd_idx, rd_last}, {1'b1, 7'd1, 1'b0});
    held = rd_data;
    start = 1; num_samples = 7; tick();
    start = 0;
    chk("st_hold1", {rd_valid, rd_idx, rd_last, rd_data, busy}, {1'b1, 7'd1, 1'b0, held, 1'b1});
    tick();
    chk("st_hold2", {rd_valid, rd_idx, rd_last, rd_data}, {1'b1, 7'd1, 1'b0, held});
    readout(1);
    chk("t3_bin1", got[1], 1);
    chk("t3_bin2", got[2], 2);
    chk("t3_bin85", got[85], 1);
    chk("t3_miss", got[NB], 0);
    chk("t3_done", {busy, done}, 2'b01);

    // Reset mid-ACQUIRE after 3 samples, with start and cfg_we in the same cycle.
    start = 1; num_samples = 10; tick();
    start = 0;
    push(5); push(5); push(5);
    sample_valid = 0;
    reset = 1; start = 1; cfg_we = 1; cfg_addr = 1; cfg_tag = 8'h77; tick();
    reset = 0; start = 0; cfg_we = 0;
    chk("rst_mid", {busy, done, rd_valid, rd_idx, rd_data}, 0);
    tick();
    chk("rst_idle", {busy, done}, 0);

    // Zero budget: one ACQUIRE cycle, bins all cleared.
    start = 1; num_samples = 0; tick();
    start = 0; sample_valid = 1; sample = 5;
    chk("z_acq", {busy, rd_valid}, 2'b10);
    tick();
    sample_valid = 0;
    chk("z_ro", {busy, rd_valid}, 2'b11);
    readout(0);
    sum = 0;
    for (int i = 0; i <= NB; i++) sum += got[i];
    chk("z_sum", sum, 0);

    // Saturation on the CNT_W=4 instance; sample 1 also shows tag[1] restored.
    start = 1; num_samples = 20; tick();
    start = 0;
    for (int i = 0; i < 20; i++) push(1);
    chk("sat_wait", {busy, rd_valid, busy4, rd_valid4}, 4'b1010);
    tick();
    sample_valid = 0;
    chk("sat_ro", {rd_valid, rd_valid4}, 2'b11);
    readout(0);
    chk("sat_bin1_32", got[1], 20);
    chk("sat_bin1_4", got4[1], 15);
    chk("sat_miss", {got[NB], got4[NB]}, 0);
    chk("sat_done", {done, done4}, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
